// File: rtl/hpu_palette.sv
// hpu_palette: 32x12 colour palette with a double-buffered bulk loader that
// fetches 64 bytes from shared memory at line 490 and swaps them in atomically.
`default_nettype none

module hpu_palette (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  true_line,
  input  logic [9:0]  true_column,
  input  logic [4:0]  pixel_in,
  output logic [15:0] addr_out,
  input  logic [7:0]  data_in,
  output logic        bus_req,
  output logic [11:0] rgb_out,
  output logic        load_done
);

  localparam logic [15:0] BASE_ADDR  = 16'h2AC0;
  localparam logic [9:0]  LOAD_LINE  = 10'd490;
  localparam logic [9:0]  VIS_LINES  = 10'd480;
  localparam logic [9:0]  VIS_COLS   = 10'd800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [11:0] shadow [32];
  logic [11:0] active [32];

  logic        start;
  logic [5:0]  byte_sel;
  logic [4:0]  eff;
  logic        blank;

  assign start    = (true_line == LOAD_LINE) && (true_column == 10'd0);
  assign byte_sel = idx - 6'd1;
  assign eff      = (pixel_in[2:0] == 3'd0) ? 5'd0 : pixel_in;
  assign blank    = (true_line >= VIS_LINES) || (true_column >= VIS_COLS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 6'd0;
      addr_out  <= 16'd0;
      bus_req   <= 1'b0;
      load_done <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        shadow[i] <= 12'd0;
        active[i] <= 12'd0;
      end
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            idx     <= 6'd0;
            bus_req <= 1'b1;
          end
        end
        LOAD: begin
          addr_out <= BASE_ADDR + {10'd0, idx};
          // data_in lags the issued address by one cycle
          if (idx != 6'd0) begin
            if (byte_sel[0])
              shadow[byte_sel[5:1]][11:8] <= data_in[3:0];
            else
              shadow[byte_sel[5:1]][7:0]  <= data_in;
          end
          idx <= idx + 6'd1;
          if (idx == 6'd63)
            state <= LAST;
        end
        LAST: begin
          shadow[31][11:8] <= data_in[3:0];
          // Whole palette swaps in one edge so a partial load is never seen
          for (int i = 0; i < 31; i++)
            active[i] <= shadow[i];
          active[31] <= {data_in[3:0], shadow[31][7:0]};
          bus_req    <= 1'b0;
          load_done  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rgb_out <= 12'd0;
    else if (blank)
      rgb_out <= 12'd0;
    else
      rgb_out <= active[eff];
  end

endmodule

`default_nettype wire
